// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer arbiter.
package fb_pkg;

    localparam int FB_ADDR_W    = 15;
    localparam int FB_DATA_W    = 8;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [0:0] {
        ARB_RD_PRIO  = 1'b0,
        ARB_WR_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/framebuf_arbiter_starve_counter.sv
// Saturating count of consecutive denied writer cycles.
// limit_hit_o flags the edge on which the count reaches LIMIT.
module starve_counter
    import fb_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clk_in,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic limit_hit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Flag on the increment itself so the forced slot lands on the very next cycle.
    assign limit_hit_o = inc_i && (cnt_q == (LIMIT_C - STARVE_CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT_C)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/framebuf_arbiter.sv
// Single-port frame-buffer RAM arbiter: reader has priority, writer gets a
// forced slot after STARVE_LIMIT consecutive denied cycles.
module framebuf_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_en,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic              limit_hit;
    logic              enter_force;
    logic              rd_accept;
    logic              wr_accept;

    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] ram_wdata_d;
    logic              ram_en_q;
    logic              ram_en_d;
    logic              ram_we_q;
    logic              ram_we_d;
    logic [1:0]        rd_vld_q;

    assign rd_accept   = rd_req && rd_gnt;
    assign wr_accept   = wr_req && wr_gnt;
    assign enter_force = (state_q == ARB_RD_PRIO) && limit_hit;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_in      (clk_in),
        .rst         (rst),
        .inc_i       (wr_req && !wr_gnt),
        .clr_i       (!wr_req || wr_accept || enter_force),
        .limit_hit_o (limit_hit)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ARB_RD_PRIO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_RD_PRIO:  if (limit_hit) state_d = ARB_WR_FORCE;
            ARB_WR_FORCE: state_d = ARB_RD_PRIO;
            default:      state_d = ARB_RD_PRIO;
        endcase
    end

    always_comb begin
        rd_gnt = 1'b0;
        wr_gnt = 1'b0;
        unique case (state_q)
            ARB_RD_PRIO: begin
                rd_gnt = rd_req;
                wr_gnt = wr_req && !rd_req;
            end
            ARB_WR_FORCE: wr_gnt = wr_req;
            default: ;
        endcase
    end

    // Address and write data hold when no transfer is accepted.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        if (rd_accept) begin
            ram_en_d   = 1'b1;
            ram_addr_d = rd_addr;
        end else if (wr_accept) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            rd_vld_q    <= 2'b00;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            rd_vld_q    <= {rd_vld_q[0], rd_accept};
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign rd_valid  = rd_vld_q[1];
    assign rd_data   = ram_rdata;

endmodule
